// File: rtl/chip8_sound_ctrl.sv
// Chip-8 sound controller: owns the 60 Hz sound timer (ST) and turns a
// nonzero ST into an enveloped square-wave tone served to the codec on each
// sample request. The attack/release ramp keeps tone start and stop click-free.
module chip8_sound_ctrl #(
  parameter int unsigned TICK_DIV    = 833333,
  parameter int unsigned HALF_PERIOD = 55,
  parameter logic [15:0] AMPLITUDE   = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_we,
  input  logic [7:0]  st_wdata,
  output logic [7:0]  st_value,
  input  logic        enable,
  input  logic        sample_req,
  output logic [15:0] audio_output,
  output logic        playing
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [4:0]    ENV_MAX    = 5'd16;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   tick_count;
  logic            tick;
  logic            active;
  logic [4:0]      env;
  logic [4:0]      env_next;
  logic [PW-1:0]   phase;
  logic            sign;
  logic [15:0]     level;
  logic [15:0]     tone_sample;

  assign tick        = (tick_count == TICK_LAST);
  assign active      = (st_value != 8'd0) && enable;
  assign playing     = (state != IDLE);
  assign level       = 16'((32'(AMPLITUDE) * 32'(env)) >> 4);
  assign tone_sample = sign ? (16'd0 - level) : level;

  // Free-running 60 Hz divider; the tick lands on the cycle the count wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

  // Sound timer: a CPU write wins over a coincident tick; decrement stops at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_value <= 8'd0;
    end else if (st_we) begin
      st_value <= st_wdata;
    end else if (tick && (st_value != 8'd0)) begin
      st_value <= st_value - 1'b1;
    end
  end

  // Envelope state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and envelope step; the ramp step of the old state still
  // applies on a cycle where active flips the direction.
  always_comb begin
    next_state = state;
    env_next   = env;
    case (state)
      IDLE: begin
        if (active) next_state = ATTACK;
      end
      ATTACK: begin
        if (sample_req && (env != ENV_MAX)) env_next = env + 1'b1;
        if (!active) next_state = RELEASE;
        else if (sample_req && (env_next == ENV_MAX)) next_state = SUSTAIN;
      end
      SUSTAIN: begin
        if (!active) next_state = RELEASE;
      end
      RELEASE: begin
        if (sample_req && (env != 5'd0)) env_next = env - 1'b1;
        if (active) next_state = ATTACK;
        else if (sample_req && (env_next == 5'd0)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sample datapath: emit the current sample, advance the square-wave phase,
  // and re-arm phase/sign on entry to IDLE so tones start positive.
  always_ff @(posedge clk) begin
    if (reset) begin
      env          <= 5'd0;
      phase        <= '0;
      sign         <= 1'b0;
      audio_output <= 16'd0;
    end else begin
      env <= env_next;
      if (sample_req) begin
        if (state == IDLE) begin
          audio_output <= 16'd0;
        end else begin
          audio_output <= tone_sample;
          if (phase == PHASE_LAST) begin
            phase <= '0;
            sign  <= ~sign;
          end else begin
            phase <= phase + 1'b1;
          end
        end
      end
      if ((next_state == IDLE) && (state != IDLE)) begin
        phase <= '0;
        sign  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// Directed, self-checking bench for chip8_sound_ctrl with a short tick
// divider and a two-sample half period so the whole tone cycle fits quickly.
module tb_chip8_sound_ctrl;

  localparam int unsigned TICK_DIV    = 10;
  localparam int unsigned HALF_PERIOD = 2;
  localparam logic [15:0] AMPLITUDE   = 16'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_we;
  logic [7:0]  st_wdata;
  logic [7:0]  st_value;
  logic        enable;
  logic        sample_req;
  logic [15:0] audio_output;
  logic        playing;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  wdata;
    int          gap;
    logic [15:0] exp_audio;
    logic        exp_playing;
  } vec_t;

  vec_t vecs[38];

  chip8_sound_ctrl #(
    .TICK_DIV(TICK_DIV),
    .HALF_PERIOD(HALF_PERIOD),
    .AMPLITUDE(AMPLITUDE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .st_we(st_we),
    .st_wdata(st_wdata),
    .st_value(st_value),
    .enable(enable),
    .sample_req(sample_req),
    .audio_output(audio_output),
    .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] wdata, input logic sreq);
    st_we      = wr;
    st_wdata   = wdata;
    sample_req = sreq;
    @(posedge clk);
    #1;
    st_we      = 1'b0;
    sample_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 1'b0);
  endtask

  task automatic doSample(input string name, input logic [15:0] exp_audio);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput(name, audio_output, exp_audio);
  endtask

  // Expected tone value for sample number k (counted from IDLE) at envelope e.
  function automatic logic [15:0] toneSample(input int k, input int e);
    logic [15:0] mag;
    mag = 16'(e * 256);
    if (((k / 2) % 2) == 1) return 16'd0 - mag;
    return mag;
  endfunction

  task automatic setVec(input int i, input logic wr, input logic [7:0] wdata,
                        input int gap, input logic [15:0] ea, input logic ep);
    vecs[i].wr          = wr;
    vecs[i].wdata       = wdata;
    vecs[i].gap         = gap;
    vecs[i].exp_audio   = ea;
    vecs[i].exp_playing = ep;
  endtask

  initial begin
    // Attack (0..15), sustain (16..19), release (20..35), idle (36..37).
    setVec(0,  1'b1, 8'd200, 3, 16'h0000, 1'b1);
    setVec(1,  1'b0, 8'd0,   3, 16'h0100, 1'b1);
    setVec(2,  1'b0, 8'd0,   3, 16'hFE00, 1'b1);
    setVec(3,  1'b0, 8'd0,   3, 16'hFD00, 1'b1);
    setVec(4,  1'b0, 8'd0,   3, 16'h0400, 1'b1);
    setVec(5,  1'b0, 8'd0,   3, 16'h0500, 1'b1);
    setVec(6,  1'b0, 8'd0,   3, 16'hFA00, 1'b1);
    setVec(7,  1'b0, 8'd0,   3, 16'hF900, 1'b1);
    setVec(8,  1'b0, 8'd0,   3, 16'h0800, 1'b1);
    setVec(9,  1'b0, 8'd0,   3, 16'h0900, 1'b1);
    setVec(10, 1'b0, 8'd0,   3, 16'hF600, 1'b1);
    setVec(11, 1'b0, 8'd0,   3, 16'hF500, 1'b1);
    setVec(12, 1'b0, 8'd0,   3, 16'h0C00, 1'b1);
    setVec(13, 1'b0, 8'd0,   3, 16'h0D00, 1'b1);
    setVec(14, 1'b0, 8'd0,   3, 16'hF200, 1'b1);
    setVec(15, 1'b0, 8'd0,   3, 16'hF100, 1'b1);
    setVec(16, 1'b0, 8'd0,   3, 16'h1000, 1'b1);
    setVec(17, 1'b0, 8'd0,   3, 16'h1000, 1'b1);
    setVec(18, 1'b0, 8'd0,   3, 16'hF000, 1'b1);
    setVec(19, 1'b0, 8'd0,   3, 16'hF000, 1'b1);
    setVec(20, 1'b1, 8'd0,   3, 16'h1000, 1'b1);
    setVec(21, 1'b0, 8'd0,   3, 16'h0F00, 1'b1);
    setVec(22, 1'b0, 8'd0,   3, 16'hF200, 1'b1);
    setVec(23, 1'b0, 8'd0,   3, 16'hF300, 1'b1);
    setVec(24, 1'b0, 8'd0,   3, 16'h0C00, 1'b1);
    setVec(25, 1'b0, 8'd0,   3, 16'h0B00, 1'b1);
    setVec(26, 1'b0, 8'd0,   3, 16'hF600, 1'b1);
    setVec(27, 1'b0, 8'd0,   3, 16'hF700, 1'b1);
    setVec(28, 1'b0, 8'd0,   3, 16'h0800, 1'b1);
    setVec(29, 1'b0, 8'd0,   3, 16'h0700, 1'b1);
    setVec(30, 1'b0, 8'd0,   3, 16'hFA00, 1'b1);
    setVec(31, 1'b0, 8'd0,   3, 16'hFB00, 1'b1);
    setVec(32, 1'b0, 8'd0,   3, 16'h0400, 1'b1);
    setVec(33, 1'b0, 8'd0,   3, 16'h0300, 1'b1);
    setVec(34, 1'b0, 8'd0,   3, 16'hFE00, 1'b1);
    setVec(35, 1'b0, 8'd0,   3, 16'hFF00, 1'b0);
    setVec(36, 1'b0, 8'd0,   3, 16'h0000, 1'b0);
    setVec(37, 1'b0, 8'd0,   3, 16'h0000, 1'b0);

    reset      = 1'b1;
    st_we      = 1'b0;
    st_wdata   = 8'd0;
    enable     = 1'b1;
    sample_req = 1'b0;

    // Reset state.
    idle(3);
    checkOutput("reset st_value", st_value, 16'd0);
    checkOutput("reset audio", audio_output, 16'd0);
    checkOutput("reset playing", playing, 16'd0);
    reset = 1'b0;
    idle(1);
    checkOutput("post-reset playing", playing, 16'd0);

    // Timer countdown without sample requests.
    applyStimulus(1'b1, 8'd3, 1'b0);
    checkOutput("countdown load", st_value, 16'd3);
    checkOutput("playing 1 cycle after write", playing, 16'd0);
    idle(1);
    checkOutput("playing 2 cycles after write", playing, 16'd1);
    for (int i = 0; i < 12 && st_value != 8'd2; i++) idle(1);
    checkOutput("countdown reaches 2", st_value, 16'd2);
    idle(9);
    checkOutput("countdown holds 2 within tick", st_value, 16'd2);
    idle(1);
    checkOutput("countdown 1", st_value, 16'd1);
    idle(10);
    checkOutput("countdown 0", st_value, 16'd0);
    idle(25);
    checkOutput("countdown holds 0", st_value, 16'd0);
    checkOutput("playing held without samples", playing, 16'd1);
    doSample("release from env 0", 16'd0);
    checkOutput("idle after empty release", playing, 16'd0);

    // Table-driven attack, sustain, release and idle.
    for (int i = 0; i < 38; i++) begin
      if (vecs[i].wr) applyStimulus(1'b1, vecs[i].wdata, 1'b0);
      idle(vecs[i].gap);
      if (i > 0) checkOutput($sformatf("vec%0d hold", i), audio_output, vecs[i-1].exp_audio);
      doSample($sformatf("vec%0d audio", i), vecs[i].exp_audio);
      checkOutput($sformatf("vec%0d playing", i), playing, 16'(vecs[i].exp_playing));
    end

    // Retrigger mid-release: attack resumes from env 8.
    applyStimulus(1'b1, 8'd200, 1'b0);
    idle(3);
    for (int k = 0; k < 16; k++) begin
      idle(3);
      doSample($sformatf("retrig attack k%0d", k), toneSample(k, k));
    end
    applyStimulus(1'b1, 8'd0, 1'b0);
    idle(2);
    for (int k = 16; k < 24; k++) begin
      idle(3);
      doSample($sformatf("retrig release k%0d", k), toneSample(k, 32 - k));
    end
    applyStimulus(1'b1, 8'd50, 1'b0);
    idle(2);
    for (int k = 24; k < 33; k++) begin
      idle(3);
      doSample($sformatf("retrig resume k%0d", k), toneSample(k, (k < 32) ? k - 16 : 16));
    end
    checkOutput("retrig playing", playing, 16'd1);

    // enable=0 during sustain: release ramp while ST keeps counting.
    enable = 1'b0;
    applyStimulus(1'b1, 8'd40, 1'b0);
    checkOutput("disable load", st_value, 16'd40);
    for (int k = 33; k < 40; k++) begin
      idle(3);
      doSample($sformatf("disable release k%0d", k), toneSample(k, 49 - k));
    end
    idle(2);
    checkOutput("ST counts while disabled", st_value, 16'd37);
    checkOutput("playing during disabled release", playing, 16'd1);

    // Reset mid-attack.
    enable = 1'b1;
    idle(3);
    idle(3);
    doSample("attack before reset k40", toneSample(40, 9));
    idle(3);
    doSample("attack before reset k41", toneSample(41, 10));
    reset = 1'b1;
    idle(1);
    checkOutput("mid-tone reset st_value", st_value, 16'd0);
    checkOutput("mid-tone reset audio", audio_output, 16'd0);
    checkOutput("mid-tone reset playing", playing, 16'd0);
    reset = 1'b0;
    idle(3);
    checkOutput("after reset playing", playing, 16'd0);
    applyStimulus(1'b1, 8'd20, 1'b0);
    idle(3);
    doSample("fresh tone k0", 16'h0000);
    idle(3);
    doSample("fresh tone starts positive", 16'h0100);

    // Write coinciding with a tick: the write wins.
    applyStimulus(1'b1, 8'd10, 1'b0);
    for (int i = 0; i < 15 && st_value != 8'd9; i++) idle(1);
    checkOutput("tick align reaches 9", st_value, 16'd9);
    idle(9);
    applyStimulus(1'b1, 8'd5, 1'b0);
    checkOutput("write beats tick", st_value, 16'd5);
    idle(9);
    checkOutput("written value holds", st_value, 16'd5);
    idle(1);
    checkOutput("divider undisturbed by write", st_value, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
